cla_adder: RTL and testbench

CLA_ADDER -- requirements
Module: cla_adder

---
 rtl/cla_adder.sv | 138 +++++++++++++
 tb/tb_cla_adder.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/cla_adder.sv
// Registered two-level carry-lookahead adder.
// Operands are split into 4-bit groups. Each group forms its internal carries and
// its group generate/propagate as flat sum-of-products. A second-level lookahead
// unit turns group G/P plus InputCarry into every group carry-in, again as a flat
// sum-of-products, so no carry ever ripples through a chain of groups.
// {OutputCarry, Sum} is registered and has one cycle of latency.
// Reset is synchronous and active-high, and it wins over the addition.

module cla_adder #(
    parameter int unsigned Width = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [Width-1:0] InputA,
    input  logic [Width-1:0] InputB,
    input  logic             InputCarry,
    output logic [Width-1:0] Sum,
    output logic             OutputCarry
);

    localparam int unsigned GroupSize = 4;
    localparam int unsigned NumGroups = Width / GroupSize;

    // Stop elaboration if the operand width cannot be split into whole groups.
    if ((Width % GroupSize) != 0 || Width == 0) begin : gWidthCheck
        $error("cla_adder: Width must be a non-zero multiple of 4");
    end

    // Per-bit generate and propagate.
    logic [Width-1:0] bitGen;
    logic [Width-1:0] bitProp;

    // Carry into each bit position. carry[0] is InputCarry.
    logic [Width-1:0] carry;

    // Group-level signals. groupCarry[j] is the carry into group j.
    // groupCarry[NumGroups] is the carry out of the top group.
    logic [NumGroups-1:0] groupGen;
    logic [NumGroups-1:0] groupProp;
    logic [NumGroups:0]   groupCarry;

    // Next-state values for the output register.
    logic [Width-1:0] sumD;
    logic             carryOutD;
    logic [Width-1:0] sumQ;
    logic             carryOutQ;

    assign bitGen  = InputA & InputB;
    assign bitProp = InputA ^ InputB;

    // First level: each 4-bit group produces c1..c3, G and P from explicit
    // two-level products. None of these terms depends on another group's carry.
    for (genvar j = 0; j < NumGroups; j++) begin : gGroup
        logic [3:0] g;
        logic [3:0] p;
        logic       cin;

        assign g   = bitGen[GroupSize*j +: GroupSize];
        assign p   = bitProp[GroupSize*j +: GroupSize];
        assign cin = groupCarry[j];

        assign carry[GroupSize*j] = cin;

        assign carry[GroupSize*j + 1] = g[0]
                                      | (p[0] & cin);

        assign carry[GroupSize*j + 2] = g[1]
                                      | (p[1] & g[0])
                                      | (p[1] & p[0] & cin);

        assign carry[GroupSize*j + 3] = g[2]
                                      | (p[2] & g[1])
                                      | (p[2] & p[1] & g[0])
                                      | (p[2] & p[1] & p[0] & cin);

        assign groupGen[j] = g[3]
                           | (p[3] & g[2])
                           | (p[3] & p[2] & g[1])
                           | (p[3] & p[2] & p[1] & g[0]);

        assign groupProp[j] = p[3] & p[2] & p[1] & p[0];
    end

    // Second-level lookahead term for the carry out of group j:
    //   G[j] | P[j]G[j-1] | ... | P[j]..P[1]G[0] | P[j]..P[0]cin
    // Each product is formed independently and then ORed together.
    function automatic logic lookaheadCarry(
        input int                   j,
        input logic [NumGroups-1:0] gg,
        input logic [NumGroups-1:0] pp,
        input logic                 cin
    );
        logic acc;
        logic term;
        acc = 1'b0;
        for (int k = 0; k <= j; k++) begin
            term = gg[k];
            for (int m = k + 1; m <= j; m++) begin
                term = term & pp[m];
            end
            acc = acc | term;
        end
        term = cin;
        for (int m = 0; m <= j; m++) begin
            term = term & pp[m];
        end
        return acc | term;
    endfunction

    assign groupCarry[0] = InputCarry;

    // Second level: the carry into every group comes directly from group G/P and
    // InputCarry.
    for (genvar j = 0; j < NumGroups; j++) begin : gLookahead
        assign groupCarry[j+1] = lookaheadCarry(j, groupGen, groupProp, InputCarry);
    end

    // Sum bits and carry out of the most significant group.
    always_comb begin
        sumD      = bitProp ^ carry;
        carryOutD = groupCarry[NumGroups];
    end

    // Output register: reset clears it, otherwise it captures the new sum.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            sumQ      <= '0;
            carryOutQ <= 1'b0;
        end else begin
            sumQ      <= sumD;
            carryOutQ <= carryOutD;
        end
    end

    assign Sum         = sumQ;
    assign OutputCarry = carryOutQ;

endmodule

// File: tb/tb_cla_adder.sv
// Scoreboard bench for cla_adder at Width = 8.
// The driver applies one operand set per cycle on the falling edge and pushes the
// expected registered result into a queue. The monitor pops one entry after each
// rising edge and compares it. On the next falling edge, after new inputs have
// been applied, the monitor also checks that the outputs did not move.

module tb_cla_adder;

    localparam int unsigned Width = 8;

    logic             Clock;
    logic             Reset;
    logic [Width-1:0] InputA;
    logic [Width-1:0] InputB;
    logic             InputCarry;
    logic [Width-1:0] Sum;
    logic             OutputCarry;

    typedef struct {
        logic [Width-1:0] sum;
        logic             cout;
        string            name;
    } expect_t;

    expect_t expQ[$];

    int vectors;
    int miscompares;

    cla_adder #(
        .Width(Width)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .InputA     (InputA),
        .InputB     (InputB),
        .InputCarry (InputCarry),
        .Sum        (Sum),
        .OutputCarry(OutputCarry)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Reference model: plain integer addition, wrapped to Width+1 bits.
    function automatic logic [Width:0] refAdd(input int a, input int b, input int c);
        int total;
        total = a + b + c;
        return total[Width:0];
    endfunction

    // Apply one cycle of stimulus and record the expected result.
    task automatic drive(input int a, input int b, input int c, input logic rst,
                         input string name);
        expect_t e;
        logic [Width:0] r;
        @(negedge Clock);
        InputA     = a[Width-1:0];
        InputB     = b[Width-1:0];
        InputCarry = c[0];
        Reset      = rst;
        r          = rst ? '0 : refAdd(a, b, c);
        e.sum      = r[Width-1:0];
        e.cout     = r[Width];
        e.name     = name;
        expQ.push_back(e);
    endtask

    // Directed cycle whose expected values are written out by hand.
    task automatic driveExp(input int a, input int b, input int c, input logic rst,
                            input int expSum, input int expCout, input string name);
        expect_t e;
        @(negedge Clock);
        InputA     = a[Width-1:0];
        InputB     = b[Width-1:0];
        InputCarry = c[0];
        Reset      = rst;
        e.sum      = expSum[Width-1:0];
        e.cout     = expCout[0];
        e.name     = name;
        expQ.push_back(e);
    endtask

    // Monitor: check the result after each rising edge, and check that it is
    // still held after the inputs change on the falling edge.
    initial begin : monitor
        logic [Width-1:0] heldSum;
        logic             heldCout;
        bit               haveHeld;
        expect_t          e;
        haveHeld = 1'b0;
        forever begin
            @(posedge Clock);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                vectors++;
                if (Sum !== e.sum || OutputCarry !== e.cout) begin
                    miscompares++;
                    $display("FAIL %s: got Sum=%0d OutputCarry=%b, want Sum=%0d OutputCarry=%b",
                             e.name, Sum, OutputCarry, e.sum, e.cout);
                end
                heldSum  = e.sum;
                heldCout = e.cout;
                haveHeld = 1'b1;
            end
            @(negedge Clock);
            #1;
            if (haveHeld) begin
                vectors++;
                if (Sum !== heldSum || OutputCarry !== heldCout) begin
                    miscompares++;
                    $display("FAIL hold: got Sum=%0d OutputCarry=%b, want Sum=%0d OutputCarry=%b",
                             Sum, OutputCarry, heldSum, heldCout);
                end
            end
        end
    end

    initial begin : stimulus
        vectors     = 0;
        miscompares = 0;
        Reset       = 1'b1;
        InputA      = '0;
        InputB      = '0;
        InputCarry  = 1'b0;

        // Reset held for two cycles while operands are present.
        driveExp(200, 100, 0, 1'b1, 0, 0, "reset1");
        driveExp(200, 100, 0, 1'b1, 0, 0, "reset2");

        // The first edge after reset loads the sum.
        driveExp(5,   12,  0, 1'b0, 17,  0, "5+12");
        driveExp(0,   0,   0, 1'b0, 0,   0, "0+0");
        driveExp(128, 127, 0, 1'b0, 255, 0, "128+127");
        driveExp(255, 1,   0, 1'b0, 0,   1, "255+1");
        driveExp(255, 255, 1, 1'b0, 255, 1, "255+255+1");
        driveExp(0,   0,   1, 1'b0, 1,   0, "0+0+1");
        driveExp(15,  1,   0, 1'b0, 16,  0, "group carry");

        // A reset pulse between operand changes discards that cycle's result.
        driveExp(10,  20,  0, 1'b0, 30,  0, "pre-pulse");
        driveExp(99,  99,  1, 1'b1, 0,   0, "reset pulse");
        driveExp(7,   8,   1, 1'b0, 16,  0, "post-pulse");

        // New random operands every cycle.
        for (int i = 0; i < 500; i++) begin
            drive($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 1),
                  ($urandom_range(0, 31) == 0), "random");
        end

        // Sweep every A and B. Cin takes two mixed patterns so both values occur
        // across every group boundary.
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 256; b++) begin
                drive(a, b, ((a ^ b ^ (a >> 4)) & 1), 1'b0, "sweep");
            end
        end

        // Wait a bounded time for the scoreboard to drain.
        repeat (4) @(posedge Clock);
        #2;
        vectors++;
        if (expQ.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending results, want 0", expQ.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
